// File: rtl/collide_pkg.sv
// Shared types for the collision-run sequencer: FSM states and memory-owner encodings.
package collide_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SETTLE,
    RUN,
    DRAIN,
    DONE,
    ABORT
  } state_e;

  localparam logic MEM_HOST   = 1'b0;
  localparam logic MEM_ENGINE = 1'b1;

endpackage

// File: rtl/collide_run_timer.sv
// Up-counter cleared on load, flagging when it equals the supplied terminal value.
module collide_run_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         flagRst2,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d = clr_i ? '0 : cnt_q + W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge flagRst2) begin
    if (flagRst2) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/collide_run_ctrl.sv
// Sequences one collision-engine run: reset pulse, memory hand-over, wait for done/timeout, hand-back.
module collide_run_ctrl
  import collide_pkg::*;
#(
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT_W     = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             flagRst2,
  input  logic             cs,
  input  logic             done_collide,
  input  logic             collide_hit,
  output logic             eng_rst_n,
  output logic             mem_owner,
  output logic             busy,
  output logic             done_pulse,
  output logic             hit,
  output logic             timeout_err,
  output logic             abort_err,
  output logic [CNT_W-1:0] run_count
);

  localparam logic [TIMEOUT_W-1:0] RST_LAST    = TIMEOUT_W'(RST_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] RUN_LAST    = '1 - TIMEOUT_W'(1);

  state_e             state_q, state_d;
  logic               cs_q, dc_q;
  logic               hit_q, hit_d;
  logic               timeout_q, timeout_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   run_count_q, run_count_d;
  logic [TIMEOUT_W-1:0] term;
  logic               tc;
  logic               start;
  logic               done_edge;

  assign start     = cs && !cs_q;
  assign done_edge = done_collide && !dc_q;

  always_comb begin
    unique case (state_q)
      RST, ABORT: term = RST_LAST;
      SETTLE:     term = SETTLE_LAST;
      default:    term = RUN_LAST;
    endcase
  end

  collide_run_timer #(.W(TIMEOUT_W)) u_timer (
    .clk      (clk),
    .flagRst2 (flagRst2),
    .clr_i    (state_d != state_q),
    .term_i   (term),
    .tc_o     (tc)
  );

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    timeout_d   = timeout_q;
    abort_d     = abort_q;
    run_count_d = run_count_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d   = RST;
        hit_d     = 1'b0;
        timeout_d = 1'b0;
        abort_d   = 1'b0;
      end
      RST: begin
        if (!cs)     state_d = ABORT;
        else if (tc) state_d = SETTLE;
      end
      SETTLE: begin
        if (!cs)     state_d = ABORT;
        else if (tc) state_d = RUN;
      end
      // cs drop outranks completion; a done edge outranks the timeout in the same cycle.
      RUN: begin
        if (!cs) begin
          state_d = ABORT;
        end else if (done_edge) begin
          hit_d   = collide_hit;
          state_d = DRAIN;
        end else if (tc) begin
          timeout_d = 1'b1;
          hit_d     = 1'b0;
          state_d   = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        run_count_d = run_count_q + CNT_W'(1);
        state_d     = IDLE;
      end
      ABORT:   if (tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ABORT && state_q != ABORT) abort_d = 1'b1;
  end

  always_ff @(posedge clk or posedge flagRst2) begin
    if (flagRst2) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      dc_q        <= 1'b0;
      hit_q       <= 1'b0;
      timeout_q   <= 1'b0;
      abort_q     <= 1'b0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs;
      dc_q        <= done_collide;
      hit_q       <= hit_d;
      timeout_q   <= timeout_d;
      abort_q     <= abort_d;
      run_count_q <= run_count_d;
    end
  end

  assign eng_rst_n   = (state_q == SETTLE) || (state_q == RUN) || (state_q == DRAIN);
  assign mem_owner   = ((state_q == SETTLE) || (state_q == RUN)) ? MEM_ENGINE : MEM_HOST;
  assign busy        = (state_q != IDLE);
  assign done_pulse  = (state_q == DONE);
  assign hit         = hit_q;
  assign timeout_err = timeout_q;
  assign abort_err   = abort_q;
  assign run_count   = run_count_q;

endmodule

// File: tb/tb_collide_run_ctrl.sv
// Bench for collide_run_ctrl: fixed vectors, directed corner sequences and a randomized run vs a run-age model.
module tb_collide_run_ctrl;

  localparam int RST_C   = 2;
  localparam int SET_C   = 2;
  localparam int TW      = 4;
  localparam int CW      = 2;
  localparam int RUN_MAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          flagRst2;
  logic          cs, done_collide, collide_hit;
  logic          eng_rst_n, mem_owner, busy, done_pulse, hit, timeout_err, abort_err;
  logic [CW-1:0] run_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  collide_run_ctrl #(
    .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C), .TIMEOUT_W(TW), .CNT_W(CW)
  ) dut (
    .clk(clk), .flagRst2(flagRst2), .cs(cs), .done_collide(done_collide),
    .collide_hit(collide_hit), .eng_rst_n(eng_rst_n), .mem_owner(mem_owner),
    .busy(busy), .done_pulse(done_pulse), .hit(hit), .timeout_err(timeout_err),
    .abort_err(abort_err), .run_count(run_count)
  );

  // Model: a run is tracked by its age in cycles since the start edge and the age at which it ended.
  bit m_active;
  int m_age, m_end, m_abort_left, m_count;
  bit m_hit, m_to, m_ab, m_pcs, m_pdc;

  typedef struct packed {
    logic cs, dc, ch;
    logic eng, mem, bsy, pulse;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_age = 0; m_end = -1; m_abort_left = 0; m_count = 0;
    m_hit = 0; m_to = 0; m_ab = 0; m_pcs = 0; m_pdc = 0;
  endtask

  task automatic model_step(input bit c, input bit d, input bit h);
    int rs = RST_C + SET_C;
    if (m_abort_left > 0) begin
      m_abort_left--;
    end else if (!m_active) begin
      if (c && !m_pcs) begin
        m_active = 1; m_age = 0; m_end = -1; m_hit = 0; m_to = 0; m_ab = 0;
      end
    end else if (m_end < 0 && !c) begin
      m_active = 0; m_abort_left = RST_C; m_ab = 1;
    end else if (m_end < 0) begin
      if (m_age >= rs) begin
        if (d && !m_pdc) begin
          m_hit = h; m_end = m_age + 1;
        end else if (m_age - rs + 1 == RUN_MAX) begin
          m_to = 1; m_hit = 0; m_end = m_age + 1;
        end
      end
      m_age++;
    end else if (m_age == m_end) begin
      m_age++;
    end else begin
      m_count = (m_count + 1) % (1 << CW);
      m_active = 0;
    end
    m_pcs = c; m_pdc = d;
  endtask

  function automatic logic [8:0] model_outs();
    bit pulse, eng, mem;
    pulse = m_active && m_end >= 0 && m_age == m_end + 1;
    eng   = m_active && m_age >= RST_C && !pulse;
    mem   = m_active && m_age >= RST_C && m_end < 0;
    return {eng, mem, m_active || (m_abort_left > 0), pulse, m_hit, m_to, m_ab, CW'(m_count)};
  endfunction

  function automatic logic [8:0] dut_outs();
    return {eng_rst_n, mem_owner, busy, done_pulse, hit, timeout_err, abort_err, run_count};
  endfunction

  // Inputs are applied at the falling edge, sampled by the next rising edge, checked at the following fall.
  task automatic cycle(input bit c, input bit d, input bit h);
    cs = c; done_collide = d; collide_hit = h;
    @(posedge clk);
    model_step(c, d, h);
    @(negedge clk);
    check("outputs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  vec_t tbl[12];

  initial begin
    bit c, d;

    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 0, 1, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 1, 1, 1, 0};
    for (int i = 4; i < 9; i++) tbl[i] = '{1, 0, 0, 1, 1, 1, 0};
    tbl[9]  = '{1, 1, 1, 1, 0, 1, 0};
    tbl[10] = '{1, 1, 1, 0, 0, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 0};

    flagRst2 = 1'b1; cs = 1'b0; done_collide = 1'b0; collide_hit = 1'b0;
    model_reset();
    #1;
    check("reset_outs", 32'(dut_outs()), 32'(9'b0));
    repeat (2) @(negedge clk);
    check("reset_hold", 32'(dut_outs()), 32'(9'b0));
    flagRst2 = 1'b0;
    repeat (2) cycle(0, 0, 0);
    check("idle_eng_rst_n", 32'(eng_rst_n), 32'(0));

    // Nominal run: start edge, reset pulse, settle, done edge with a hit.
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].cs, tbl[i].dc, tbl[i].ch);
      check($sformatf("vec%0d", i), 32'({eng_rst_n, mem_owner, busy, done_pulse}),
            32'({tbl[i].eng, tbl[i].mem, tbl[i].bsy, tbl[i].pulse}));
    end
    check("nominal_hit", 32'(hit), 32'(1));
    check("nominal_count", 32'(run_count), 32'(1));

    // Abort by dropping cs during SETTLE.
    cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("abort_err", 32'(abort_err), 32'(1));
    check("abort_eng", 32'({eng_rst_n, mem_owner, busy}), 32'(3'b001));
    cycle(0, 0, 0);
    check("abort_hold", 32'(busy), 32'(1));
    cycle(0, 0, 0);
    check("abort_idle", 32'(busy), 32'(0));
    check("abort_count", 32'(run_count), 32'(1));

    // Timeout: 15 RUN cycles with no done.
    for (int i = 0; i < 4 + RUN_MAX + 1; i++) cycle(1, 0, 0);
    check("timeout_err", 32'({timeout_err, hit, mem_owner, done_pulse}), 32'(4'b1000));
    cycle(1, 0, 0);
    check("timeout_pulse", 32'(done_pulse), 32'(1));
    cycle(1, 0, 0);
    check("timeout_count", 32'(run_count), 32'(2));

    // cs held high: no retrigger.
    repeat (25) cycle(1, 0, 0);
    check("held_no_run", 32'({busy, run_count}), 32'({1'b0, 2'd2}));

    // Second run after cs low/high; done edge coincides with the timeout cycle.
    cycle(0, 0, 0);
    for (int i = 0; i < 4 + RUN_MAX; i++) cycle(1, 0, 0);
    cycle(1, 1, 1);
    check("tie_done_wins", 32'({timeout_err, hit}), 32'(2'b01));
    cycle(1, 1, 1);
    cycle(1, 0, 0);
    check("tie_count", 32'(run_count), 32'(3));

    // Fourth completed run wraps the 2-bit counter.
    cycle(0, 0, 0);
    repeat (5) cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    check("count_wrap", 32'(run_count), 32'(0));
    check("wrap_hit", 32'(hit), 32'(0));

    // done already high on RUN entry is not an edge.
    cycle(0, 1, 1);
    repeat (8) cycle(1, 1, 1);
    check("done_level_ignored", 32'({mem_owner, busy}), 32'(2'b11));
    cycle(0, 0, 0);
    repeat (3) cycle(0, 0, 0);

    // Asynchronous reset mid-RUN.
    repeat (6) cycle(1, 0, 0);
    check("pre_reset_run", 32'(mem_owner), 32'(1));
    flagRst2 = 1'b1;
    #1;
    model_reset();
    check("midrun_reset", 32'({eng_rst_n, mem_owner, busy, run_count}), 32'(5'b0));
    @(negedge clk);
    flagRst2 = 1'b0;
    repeat (3) cycle(0, 0, 0);
    check("post_reset_idle", 32'({busy, done_pulse}), 32'(2'b00));

    // Randomized traffic against the model.
    c = 0; d = 0;
    for (int i = 0; i < 3000; i++) begin
      if (c) c = ($urandom_range(0, 49) != 0);
      else   c = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 15) == 0);
      cycle(c, d, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collide_run_ctrl.md
Name: collide_run_ctrl

Overview:
- Sequencer for one run of the collision-detection engine.
- On a host start request it does four things in order: pulses the engine's active-low reset, hands the shared object memory to the engine, waits for done_collide (with timeout), then returns the memory to the JTAG host.
- It latches the result and status and counts completed runs.
- Sits between the JTAG memory interface (cs) and the collision engine. Replaces ad-hoc reset pulsing with one explicit FSM.

Parameters:
- RST_CYCLES, 2: cycles eng_rst_n is held low per reset pulse (>=1).
- SETTLE_CYCLES, 2: cycles after reset release, with memory granted to the engine, before the run window opens (>=1).
- TIMEOUT_W, 16: width of the run timer; the run times out after 2^TIMEOUT_W-1 cycles in RUN.
- CNT_W, 8: width of run_count.

Ports:
- clk  in  1  system clock.
- flagRst2  in  1  block reset.
- cs  in  1  host chip-select / run request (level, synchronous to clk).
- done_collide  in  1  engine completion (level, synchronous).
- collide_hit  in  1  engine result, valid when done_collide=1.
- eng_rst_n  out  1  engine reset, active-low.
- mem_owner  out  1  shared memory select: 0=host, 1=engine.
- busy  out  1  high in every state except IDLE.
- done_pulse  out  1  one-cycle completion strobe.
- hit  out  1  latched collide_hit of the last completed run.
- timeout_err  out  1  last run ended by timeout.
- abort_err  out  1  last run aborted by cs dropping.
- run_count  out  CNT_W  completed runs (normal or timeout), wraps.

Behaviour:
- Reset and clock: reset flagRst2, asynchronous, active-high; clock clk.
- Values while flagRst2=1:
  - state=IDLE, cs_q=0, dc_q=0
  - eng_rst_n=0 (engine held in reset)
  - mem_owner=0, busy=0, done_pulse=0
  - hit=0, timeout_err=0, abort_err=0, run_count=0
- After flagRst2 deasserts, eng_rst_n stays 0 until the first run.
- Start condition: cs=1 && cs_q=0, sampled in IDLE (cs_q is registered cs).
  - cs held high does not retrigger; cs must go low, then high again.
- On start: clear hit, timeout_err and abort_err.
- FSM (registered outputs, one transition per edge):
  - IDLE: eng_rst_n=0, mem_owner=0. Start -> RST.
  - RST: eng_rst_n=0, mem_owner=0, for RST_CYCLES cycles -> SETTLE.
  - SETTLE: eng_rst_n=1, mem_owner=1, for SETTLE_CYCLES cycles -> RUN. Timer cleared.
  - RUN: eng_rst_n=1, mem_owner=1, timer increments each cycle.
    - done_collide=1 && dc_q=0: latch hit<=collide_hit -> DRAIN.
    - timer reaches 2^TIMEOUT_W-1: timeout_err<=1, hit<=0 -> DRAIN.
    - done edge and timeout in the same cycle: done wins, timeout_err stays 0.
  - DRAIN: eng_rst_n=1, mem_owner=0 for exactly 1 cycle. Memory returns to the host before the strobe -> DONE.
  - DONE: done_pulse=1 for one cycle, run_count<=run_count+1 (2^CNT_W-1 wraps to 0), eng_rst_n=0 -> IDLE.
- Abort: cs=0 in RST, SETTLE or RUN -> ABORT.
  - ABORT: abort_err<=1, eng_rst_n=0, mem_owner=0 for RST_CYCLES cycles -> IDLE.
  - No done_pulse and no run_count change.
  - In DRAIN and DONE, cs=0 is ignored and the run completes.
- done_collide outside RUN is ignored, including done already high on RUN entry (edge only).
- Nominal latency:
  - Start edge to first RUN cycle = 1+RST_CYCLES+SETTLE_CYCLES edges.
  - done edge in RUN to done_pulse = 2 cycles.
- busy = (state != IDLE).

Decomposition:
- Shared package collide_pkg holds:
  - state enum (IDLE, RST, SETTLE, RUN, DRAIN, DONE, ABORT)
  - MEM_HOST=1'b0 and MEM_ENGINE=1'b1
- One natural sub-module: collide_run_timer, a loadable up-counter with terminal-count flag, reused for the RST, SETTLE, ABORT and RUN counts.

Test Plan:
1. flagRst2 pulse mid-RUN (RST=2, SETTLE=2) -> same cycle: eng_rst_n=0, mem_owner=0, busy=0, run_count=0; after release: state IDLE, no done_pulse.
2. cs 0->1 at edge 10, done_collide rises at edge 20 with collide_hit=1 -> eng_rst_n low edges 11-12; mem_owner=1 edges 13-21; done_pulse at edge 22; hit=1; run_count=1.
3. TIMEOUT_W=4, done never asserted -> after 15 cycles in RUN: timeout_err=1, hit=0, done_pulse once, run_count increments.
4. cs dropped during SETTLE -> abort_err=1, eng_rst_n=0 for 2 cycles, then IDLE; run_count unchanged; no done_pulse.
5. cs held high across two runs' worth of time -> only one run; after cs low then high, second run; run_count=2.
6. CNT_W=2, five complete runs -> run_count sequence 1,2,3,0,1. Done and timeout in the same cycle -> timeout_err=0, hit=collide_hit.
